// File: rtl/vram_console_writer.sv
// Text-console writer: byte stream in, character VRAM writes out, with cursor tracking.
// Optional screen clear on 0x0C is built only when CONSOLE_CLEAR_EN is defined.
`timescale 1ns/1ps
module vram_console_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        vram_we,
  output logic [10:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  output logic [4:0]  cursor_row,
  output logic [5:0]  cursor_col,
  output logic        busy
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  logic [4:0]  r_row;
  logic [5:0]  r_col;
  logic        r_we;
  logic [10:0] r_waddr;
  logic [7:0]  r_wdata;

  logic        w_accept;
  logic        w_is_print;
  logic [4:0]  w_row_adv;
  logic [4:0]  w_row_nxt;
  logic [5:0]  w_col_nxt;
  logic        w_byte_we;
  logic [10:0] w_byte_addr;
  logic [7:0]  w_byte_data;
  logic        w_we_nxt;
  logic [10:0] w_waddr_nxt;
  logic [7:0]  w_wdata_nxt;

  assign w_accept   = in_valid & in_ready;
  assign w_is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign w_row_adv  = (r_row == LAST_ROW) ? '0 : r_row + 5'd1;

  // Byte interpretation: cursor update and the write (if any) a byte requests.
  always_comb begin
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_byte_we   = 1'b0;
    w_byte_addr = r_waddr;
    w_byte_data = r_wdata;
    if (w_accept) begin
      if (w_is_print) begin
        w_byte_we   = 1'b1;
        w_byte_addr = {r_row, r_col};
        w_byte_data = in_data;
        if (r_col == LAST_COL) begin
          w_col_nxt = '0;
          w_row_nxt = w_row_adv;
        end else begin
          w_col_nxt = r_col + 6'd1;
        end
      end else begin
        case (in_data)
          CH_CR: w_col_nxt = '0;
          CH_LF: w_row_nxt = w_row_adv;
          CH_BS: begin
            if (r_col != '0) begin
              w_col_nxt   = r_col - 6'd1;
              w_byte_we   = 1'b1;
              w_byte_addr = {r_row, r_col - 6'd1};
              w_byte_data = CH_SPACE;
            end
          end
`ifdef CONSOLE_CLEAR_EN
          CH_FF: begin
            w_row_nxt = '0;
            w_col_nxt = '0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

`ifdef CONSOLE_CLEAR_EN
  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_clr_cnt;
  logic [10:0] w_clr_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // r_clr_cnt always equals the address being written this cycle while clearing.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (in_data == CH_FF)) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      ST_CLEAR: begin
        if (r_clr_cnt == '1) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 11'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == ST_IDLE);
    busy        = (r_state == ST_CLEAR);
    w_we_nxt    = w_byte_we;
    w_waddr_nxt = w_byte_addr;
    w_wdata_nxt = w_byte_data;
    if (w_state_nxt == ST_CLEAR) begin
      w_we_nxt    = 1'b1;
      w_waddr_nxt = w_clr_cnt_nxt;
      w_wdata_nxt = CH_SPACE;
    end
  end
`else
  assign in_ready    = 1'b1;
  assign busy        = 1'b0;
  assign w_we_nxt    = w_byte_we;
  assign w_waddr_nxt = w_byte_addr;
  assign w_wdata_nxt = w_byte_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row   <= '0;
      r_col   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_we    <= w_we_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  assign vram_we    = r_we;
  assign vram_waddr = r_waddr;
  assign vram_wdata = r_wdata;
  assign cursor_row = r_row;
  assign cursor_col = r_col;

endmodule
